uart_cmd_bridge: RTL
====================

// Module: uart_cmd_bridge
// PURPOSE
// - Byte-level command engine between the UART receive/transmit byte streams and the simple
//   req/gnt host port of the TL-UL host adapter; the UART is the bus master of the SoC.
// - Parses framed read/write commands from RX bytes, issues one 32-bit bus access,
//   returns status (and read data) as TX bytes.
// PARAMETERS
// - TimeoutCycles  default 100000  idle cycles between RX bytes of one frame before the frame is dropped
// - CmdWrite       default 8'h57   command byte for a write ('W')
// - CmdRead        default 8'h52   command byte for a read ('R')
// PORTS
// - clk_i       in   1   clock
// - rst_ni      in   1   async active-low reset
// - rx_valid_i  in   1   RX byte available
// - rx_data_i   in   8   RX byte
// - rx_ready_o  out  1   RX byte consumed when rx_valid_i & rx_ready_o
// - tx_valid_o  out  1   TX byte valid
// - tx_data_o   out  8   TX byte
// - tx_ready_i  in   1   TX sink accepts when tx_valid_o & tx_ready_i
// - req_o       out  1   bus request
// - gnt_i       in   1   bus grant
// - addr_o      out  32  word address, [1:0] always 0
// - we_o        out  1   1 write, 0 read
// - wdata_o     out  32  write data
// - be_o        out  4   byte enables, always 4'hF
// - valid_i     in   1   bus response valid
// - rdata_i     in   32  read data
// - err_i       in   1   bus error, qualified by valid_i
// BEHAVIOUR
// - Reset: state IDLE; rx_ready_o=0, tx_valid_o=0, tx_data_o=0, req_o=0, addr_o=0, we_o=0, wdata_o=0; be_o=4'hF.
// - Frame: CMD, ADDR[7:0], ADDR[15:8], ADDR[23:16], ADDR[31:24], then for write DATA0..DATA3 (little-endian).
// - States: IDLE -> ADDR(4 bytes) -> [DATA(4 bytes) if write] -> REQ -> WAIT -> STAT -> [RDAT(4 bytes) if read] -> IDLE.
// - rx_ready_o=1 only in IDLE/ADDR/DATA; otherwise RX is back-pressured and no byte is lost.
// - IDLE: byte==CmdWrite/CmdRead latches we, resets byte count. Any other byte -> NAK: send 8'hFE, then IDLE.
// - REQ: req_o=1 with addr_o/we_o/wdata_o stable until the gnt_i cycle; req_o=0 the next cycle. gnt_i in the same cycle as req_o rises is legal (1-cycle req).
// - WAIT: latch rdata_i and err_i on valid_i. valid_i in the gnt cycle is accepted. valid_i outside WAIT/REQ is ignored.
// - STAT: tx_data_o = 8'h00 ok / 8'h01 err; held with tx_valid_o=1 until tx_ready_i.
// - RDAT: 4 bytes rdata LSB first, each held until accepted. On err, 4 bytes 8'h00 are still sent (fixed frame length).
// - Timeout: 17-bit-or-wider counter, cleared on every accepted RX byte, counts only in ADDR/DATA.
//   When it reaches TimeoutCycles-1: drop the frame, go to IDLE, no response, no bus access.
// - addr_o[1:0] forced 0 regardless of received bits.
// - Minimum latency: last frame byte accepted -> req_o high next cycle.
// - No new frame is parsed until the full response is transmitted.
// - Reset mid-operation returns all outputs to reset values at once. A bus access already granted is abandoned; its later valid_i is ignored.
// TESTING
// - Write: RX 57 10 00 00 40 EF BE AD DE -> one req with addr 32'h4000_0010, we=1, wdata 32'hDEAD_BEEF, be F; TX 00.
// - Read: RX 52 04 00 00 40, bus returns rdata 32'h1234_5678 -> TX 00 78 56 34 12.
// - Read with err_i=1 -> TX 01 00 00 00 00; unknown byte 41 -> TX FE, no req.
// - Partial frame 57 10 00, then TimeoutCycles idle -> no req, no TX; next frame 52 ... is processed normally.
// - Back-pressure: gnt_i delayed 5 cycles, tx_ready_i toggled 0/1 -> req/addr stable, each TX byte emitted exactly once in order.
// - Misaligned addr byte 0x13 -> addr_o[1:0]=0; rst_ni asserted during WAIT -> outputs at reset values, state IDLE.

Source files
------------

// File: rtl/uart_cmd_bridge_if.sv
// uart_cmd_bridge_if
// Bundles the three streams the command bridge talks to:
//   - RX byte stream  (rx_valid_i, rx_data_i in; rx_ready_o out)
//   - TX byte stream  (tx_valid_o, tx_data_o out; tx_ready_i in)
//   - req/gnt host port toward the TL-UL host adapter
//     (req_o, addr_o, we_o, wdata_o, be_o out; gnt_i, valid_i, rdata_i, err_i in)
// Signal suffixes are seen from the bridge: the bridge uses the master modport,
// the surrounding environment (UART + host adapter) uses the slave modport.
interface uart_cmd_bridge_if;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        rx_ready_o;

    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;

    logic        req_o;
    logic        gnt_i;
    logic [31:0] addr_o;
    logic        we_o;
    logic [31:0] wdata_o;
    logic [3:0]  be_o;
    logic        valid_i;
    logic [31:0] rdata_i;
    logic        err_i;

    modport master (
        input  rx_valid_i, rx_data_i, tx_ready_i, gnt_i, valid_i, rdata_i, err_i,
        output rx_ready_o, tx_valid_o, tx_data_o, req_o, addr_o, we_o, wdata_o, be_o
    );

    modport slave (
        output rx_valid_i, rx_data_i, tx_ready_i, gnt_i, valid_i, rdata_i, err_i,
        input  rx_ready_o, tx_valid_o, tx_data_o, req_o, addr_o, we_o, wdata_o, be_o
    );
endinterface

// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge
// Byte-level command engine: parses framed read/write commands from the UART
// RX stream, performs one 32-bit access on the req/gnt host port and returns a
// status byte (plus four read-data bytes for reads) on the UART TX stream.
// Frame: CMD, ADDR[7:0..31:24], then DATA0..DATA3 for writes (little-endian).
// Responses: 00 ok / 01 error, reads append 4 data bytes (zeros on error),
// an unknown command byte is answered with FE.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   io      uart_cmd_bridge_if.master (RX stream, TX stream, host port)
module uart_cmd_bridge #(
    parameter int unsigned TimeoutCycles = 100000,
    parameter logic [7:0]  CmdWrite      = 8'h57,
    parameter logic [7:0]  CmdRead       = 8'h52
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    uart_cmd_bridge_if.master io
);
    localparam logic [31:0] TmoLast = 32'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, DATA, REQ, WAIT, STAT, RDAT, NAK
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q;
    logic [31:0] tmo_q;
    logic        we_q, err_q, rx_ready_q;
    logic [31:0] addr_q, wdata_q, rdata_q;

    logic        rx_fire;
    logic        cnt_clr, cnt_inc;
    logic        we_load, addr_load, wdata_load, rsp_load;
    logic        req;
    logic        tx_valid;
    logic [7:0]  tx_data;

    assign rx_fire = io.rx_valid_i & rx_ready_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        we_load    = 1'b0;
        addr_load  = 1'b0;
        wdata_load = 1'b0;
        rsp_load   = 1'b0;
        req        = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        unique case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    cnt_clr = 1'b1;
                    if (io.rx_data_i == CmdWrite || io.rx_data_i == CmdRead) begin
                        we_load = 1'b1;
                        state_d = ADDR;
                    end else begin
                        state_d = NAK;
                    end
                end
            end
            ADDR: begin
                if (rx_fire) begin
                    addr_load = 1'b1;
                    if (cnt_q == 2'd3) begin
                        cnt_clr = 1'b1;
                        state_d = we_q ? DATA : REQ;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else if (tmo_q == TmoLast) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (rx_fire) begin
                    wdata_load = 1'b1;
                    if (cnt_q == 2'd3) begin
                        cnt_clr = 1'b1;
                        state_d = REQ;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else if (tmo_q == TmoLast) begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                req = 1'b1;
                if (io.gnt_i) begin
                    // A response arriving together with the grant is taken here,
                    // WAIT would otherwise never see it.
                    if (io.valid_i) begin
                        rsp_load = 1'b1;
                        state_d  = STAT;
                    end else begin
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (io.valid_i) begin
                    rsp_load = 1'b1;
                    state_d  = STAT;
                end
            end
            STAT: begin
                tx_valid = 1'b1;
                tx_data  = {7'd0, err_q};
                if (io.tx_ready_i) begin
                    cnt_clr = 1'b1;
                    state_d = we_q ? IDLE : RDAT;
                end
            end
            RDAT: begin
                tx_valid = 1'b1;
                // Errored reads still return four bytes so the host frame length is fixed.
                tx_data  = err_q ? 8'h00 : rdata_q[{cnt_q, 3'b000} +: 8];
                if (io.tx_ready_i) begin
                    if (cnt_q == 2'd3) begin
                        cnt_clr = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            NAK: begin
                tx_valid = 1'b1;
                tx_data  = 8'hFE;
                if (io.tx_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= 2'd0;
            tmo_q      <= 32'd0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            rx_ready_q <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            // Registered so it is low during and right after reset, then
            // follows the states that accept RX bytes.
            rx_ready_q <= (state_d == IDLE) || (state_d == ADDR) || (state_d == DATA);

            if (cnt_clr) begin
                cnt_q <= 2'd0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + 2'd1;
            end

            // Inter-byte idle timer: runs only mid-frame, any accepted byte restarts it.
            if ((state_q == ADDR || state_q == DATA) && !rx_fire && state_d != IDLE) begin
                tmo_q <= tmo_q + 32'd1;
            end else begin
                tmo_q <= 32'd0;
            end

            if (we_load) begin
                we_q <= (io.rx_data_i == CmdWrite);
            end
            // Address is word aligned: the two low bits are dropped as they arrive.
            if (addr_load) begin
                addr_q[{cnt_q, 3'b000} +: 8] <= io.rx_data_i & ((cnt_q == 2'd0) ? 8'hFC : 8'hFF);
            end
            if (wdata_load) begin
                wdata_q[{cnt_q, 3'b000} +: 8] <= io.rx_data_i;
            end
            if (rsp_load) begin
                rdata_q <= io.rdata_i;
                err_q   <= io.err_i;
            end
        end
    end

    assign io.rx_ready_o = rx_ready_q;
    assign io.tx_valid_o = tx_valid;
    assign io.tx_data_o  = tx_data;
    assign io.req_o      = req;
    assign io.addr_o     = addr_q;
    assign io.we_o       = we_q;
    assign io.wdata_o    = wdata_q;
    assign io.be_o       = 4'hF;
endmodule
